// File: rtl/bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2to1
//
// Shares one downstream memory-bus slave between two upstream requesters
// (m0 = instruction fetch, m1 = data load/store). A registered grant FSM
// picks an owner; while a requester owns the bus its valid/address/wstrobe/
// wdata are forwarded combinationally to the slave, and the slave's
// ready/rdata are routed back to it only. The non-owner sees ready=0,
// rdata=0, and no output depends combinationally on the non-owner's inputs.
//
// Ports
//   clk, reset                  system clock; synchronous active-high reset
//   m0_valid/ready/address/     requester 0 bus (valid held until ready,
//     wstrobe/wdata/rdata         wstrobe==0 means read)
//   m1_*                        requester 1 bus, same shape as m0_*
//   s_valid/ready/address/      forwarded slave bus
//     wstrobe/wdata/rdata
//   grant[1:0]                  one-hot current owner (01=m0, 10=m1), 00 idle
//
// Parameters
//   STARVE_LIMIT  fixed-priority build only: maximum number of consecutive
//                 m0 completions while m1 is waiting (1..255)
//
// Build option
//   BUS_ARBITER_ROUND_ROBIN_EN  when defined, ties go to the requester that
//                 did not complete last; the starvation counter stays at 0.
//                 When undefined, m0 has fixed priority over m1 with the
//                 STARVE_LIMIT anti-starvation rule.
//
// States
//   state | meaning
//   IDLE  | nobody owns the bus, nothing forwarded
//   OWN0  | m0 owns the bus, m0 signals forwarded
//   OWN1  | m1 owns the bus, m1 signals forwarded
// -----------------------------------------------------------------------------
module bus_arbiter_2to1 #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_address,
    input  logic [3:0]  m0_wstrobe,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_wstrobe,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_address,
    output logic [3:0]  s_wstrobe,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

`ifndef BUS_ARBITER_ROUND_ROBIN_EN
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
`endif

    state_t     state;
    state_t     state_next;
    state_t     pick;
    logic       last_owner;
    logic       last_owner_next;
    logic [7:0] starve_cnt;
    logic [7:0] starve_cnt_next;
    logic       xfer_done;
    logic       tie_m1;

    // Encodings of OWN0/OWN1 are already the one-hot grant pattern.
    assign grant = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        starve_cnt_next = starve_cnt;
        xfer_done       = 1'b0;
        tie_m1          = 1'b0;
        pick            = IDLE;

        s_valid   = 1'b0;
        s_address = '0;
        s_wstrobe = '0;
        s_wdata   = '0;
        m0_ready  = 1'b0;
        m0_rdata  = '0;
        m1_ready  = 1'b0;
        m1_rdata  = '0;

        // Forwarding and completion bookkeeping for the current owner.
        unique case (state)
            OWN0: begin
                s_valid   = m0_valid;
                s_address = m0_address;
                s_wstrobe = m0_wstrobe;
                s_wdata   = m0_wdata;
                m0_ready  = s_ready;
                m0_rdata  = s_rdata;
                if (m0_valid && s_ready) begin
                    xfer_done       = 1'b1;
                    last_owner_next = 1'b0;
`ifndef BUS_ARBITER_ROUND_ROBIN_EN
                    if (m1_valid) begin
                        starve_cnt_next = starve_cnt + 8'd1;
                    end
`endif
                end
            end
            OWN1: begin
                s_valid   = m1_valid;
                s_address = m1_address;
                s_wstrobe = m1_wstrobe;
                s_wdata   = m1_wdata;
                m1_ready  = s_ready;
                m1_rdata  = s_rdata;
                if (m1_valid && s_ready) begin
                    xfer_done       = 1'b1;
                    last_owner_next = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Tie decisions use the post-completion view, so the completion that
        // reaches the limit hands the bus straight to m1.
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        tie_m1 = !last_owner_next;
`else
        tie_m1 = (starve_cnt_next == STARVE_MAX);
`endif

        if (m0_valid && m1_valid) begin
            pick = tie_m1 ? OWN1 : OWN0;
        end else if (m0_valid) begin
            pick = OWN0;
        end else if (m1_valid) begin
            pick = OWN1;
        end else begin
            pick = IDLE;
        end

        unique case (state)
            IDLE: begin
                state_next = pick;
            end
            OWN0: begin
                if (xfer_done) begin
                    state_next = pick;
                end else if (!m0_valid) begin
                    // Request withdrawn before ready: release the bus.
                    state_next = IDLE;
                end
            end
            OWN1: begin
                if (xfer_done) begin
                    state_next = pick;
                end else if (!m1_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == OWN1) begin
            starve_cnt_next = '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
`timescale 1ns/1ps
module tb_bus_arbiter_2to1;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_address, m0_wdata, m0_rdata;
    logic [31:0] m1_address, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrobe, m1_wstrobe;
    logic        s_valid, s_ready;
    logic [31:0] s_address, s_wdata, s_rdata;
    logic [3:0]  s_wstrobe;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    bus_arbiter_2to1 #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_address(m0_address),
        .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_address(m1_address),
        .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_address(s_address),
        .s_wstrobe(s_wstrobe), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the bus (-1 none), who completed last,
    // how many m0 completions m1 has sat through, and the slave's memory.
    int          owner;
    int          last;
    int          starve;
    logic [31:0] mem [16];
    logic        done_r [2];

    logic [1:0]  obs_grant;
    logic        obs_s_valid, obs_m0_ready, obs_m1_ready;
    logic [31:0] obs_m0_rdata, obs_m1_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int pick(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            return (last == 0) ? 1 : 0;
`else
            return (starve >= LIMIT) ? 1 : 0;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    // One bus cycle: inputs were set at the falling edge; drive slave data,
    // compare all outputs with the model, then advance the model to the
    // next rising edge and return at the following falling edge.
    task automatic tick();
        logic        own_v;
        logic [31:0] own_a, own_wd;
        logic [3:0]  own_ws;
        logic [1:0]  e_grant;
        int          idx;
        int          prev;
        own_v = 1'b0; own_a = '0; own_ws = '0; own_wd = '0;
        if (owner == 0) begin
            own_v = m0_valid; own_a = m0_address; own_ws = m0_wstrobe; own_wd = m0_wdata;
        end else if (owner == 1) begin
            own_v = m1_valid; own_a = m1_address; own_ws = m1_wstrobe; own_wd = m1_wdata;
        end
        idx = int'(own_a[5:2]);
        #1;
        s_rdata = own_v ? mem[idx] : $urandom();
        #1;
        e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        obs_grant = grant; obs_s_valid = s_valid;
        obs_m0_ready = m0_ready; obs_m1_ready = m1_ready;
        obs_m0_rdata = m0_rdata; obs_m1_rdata = m1_rdata;
        check("grant",     32'(grant),     32'(e_grant));
        check("s_valid",   32'(s_valid),   32'(own_v));
        check("s_address", s_address,      own_a);
        check("s_wstrobe", 32'(s_wstrobe), 32'(own_ws));
        check("s_wdata",   s_wdata,        own_wd);
        check("m0_ready",  32'(m0_ready),  (owner == 0) ? 32'(s_ready) : 32'd0);
        check("m1_ready",  32'(m1_ready),  (owner == 1) ? 32'(s_ready) : 32'd0);
        check("m0_rdata",  m0_rdata,       (owner == 0) ? s_rdata : 32'd0);
        check("m1_rdata",  m1_rdata,       (owner == 1) ? s_rdata : 32'd0);

        done_r[0] = 1'b0; done_r[1] = 1'b0;
        prev = owner;
        if (reset) begin
            owner = -1; last = 1; starve = 0;
        end else if (owner < 0) begin
            if (m0_valid || m1_valid) owner = pick(m0_valid, m1_valid);
        end else if (own_v && s_ready) begin
            for (int b = 0; b < 4; b++)
                if (own_ws[b]) mem[idx][8*b +: 8] = own_wd[8*b +: 8];
            done_r[prev] = 1'b1;
            last = prev;
`ifndef BUS_ARBITER_ROUND_ROBIN_EN
            if (prev == 0 && m1_valid) starve++;
`endif
            owner = pick(m0_valid, m1_valid);
        end else if (!own_v) begin
            owner = -1;
        end
        if (owner == 1) starve = 0;
        @(negedge clk);
    endtask

    task automatic idle_both();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        tick(); tick();
    endtask

    logic        pend [2];
    logic [31:0] ra [2], rd [2];
    logic [3:0]  rs [2];
    int          n0;
    logic        seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_address = 0; m0_wstrobe = 0; m0_wdata = 0;
        m1_valid = 0; m1_address = 0; m1_wstrobe = 0; m1_wdata = 0;
        s_ready = 0; s_rdata = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom();
        owner = -1; last = 1; starve = 0;
        repeat (2) @(negedge clk);

        // Reset state: everything zero while reset is held.
        tick();
        reset = 1'b0;
        tick();

        // m0 read of 0x10 holding 0xDEADBEEF, two-cycle slave.
        mem[4] = 32'hDEADBEEF;
        m0_valid = 1; m0_address = 32'h10; m0_wstrobe = 0;
        tick();
        check("t1_idle_grant", 32'(obs_grant), 32'd0);
        tick();
        check("t1_grant", 32'(obs_grant), 32'b01);
        s_ready = 1;
        tick();
        check("t1_m0_ready", 32'(obs_m0_ready), 32'd1);
        check("t1_m0_rdata", obs_m0_rdata, 32'hDEADBEEF);
        check("t1_m1_ready", 32'(obs_m1_ready), 32'd0);
        idle_both();

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        // Simultaneous reads: m0 first, m1 back-to-back.
        m0_valid = 1; m0_address = 32'h0; m1_valid = 1; m1_address = 32'h4;
        s_ready = 1;
        tick();
        tick();
        check("t2_first", 32'(obs_grant), 32'b01);
        m0_valid = 0;
        tick();
        check("t2_second", 32'(obs_grant), 32'b10);
        idle_both();
`else
        // m1 owns, m0 arrives: m0 follows with no idle cycle.
        m1_valid = 1; m1_address = 32'h4; m1_wstrobe = 0; s_ready = 0;
        tick();
        tick();
        check("t2_first", 32'(obs_grant), 32'b10);
        m0_valid = 1; m0_address = 32'h0; s_ready = 1;
        tick();
        m1_valid = 0;
        tick();
        check("t2_second", 32'(obs_grant), 32'b01);
        idle_both();
`endif

        // m1 partial write, then m0 reads the merged word.
        mem[8] = 32'hAAAAAAAA;
        m1_valid = 1; m1_address = 32'h20; m1_wstrobe = 4'b0011; m1_wdata = 32'h12345678;
        s_ready = 1;
        tick();
        tick();
        m1_valid = 0; m1_wstrobe = 0;
        m0_valid = 1; m0_address = 32'h20; m0_wstrobe = 0;
        tick();
        tick();
        tick();
        check("t3_m0_ready", 32'(obs_m0_ready), 32'd1);
        check("t3_m0_rdata", obs_m0_rdata, 32'hAAAA5678);
        idle_both();

`ifndef BUS_ARBITER_ROUND_ROBIN_EN
        // Starvation: m1 gets the bus after exactly LIMIT m0 completions.
        m0_valid = 1; m0_address = 32'h0; m1_valid = 1; m1_address = 32'h4;
        s_ready = 1; n0 = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (obs_grant == 2'b10) begin
                seen = 1;
                break;
            end
            if (obs_grant == 2'b01 && obs_m0_ready) n0++;
        end
        check("t4_m1_granted", 32'(seen), 32'd1);
        check("t4_m0_count", 32'(n0), 32'(LIMIT));
        idle_both();
`endif

        // Reset during an m1 read, then the re-request completes.
        mem[2] = 32'h0BADF00D;
        m1_valid = 1; m1_address = 32'h8; s_ready = 0;
        tick();
        tick();
        check("t5_own1", 32'(obs_grant), 32'b10);
        reset = 1;
        tick();
        reset = 0;
        tick();
        check("t5_grant", 32'(obs_grant), 32'd0);
        check("t5_s_valid", 32'(obs_s_valid), 32'd0);
        check("t5_m1_ready", 32'(obs_m1_ready), 32'd0);
        tick();
        s_ready = 1;
        tick();
        check("t5_m1_ready_after", 32'(obs_m1_ready), 32'd1);
        check("t5_m1_rdata", obs_m1_rdata, 32'h0BADF00D);
        idle_both();

        // m0 withdraws before ready; pending m1 is then served.
        m0_valid = 1; m0_address = 32'hC; s_ready = 0;
        tick();
        m1_valid = 1; m1_address = 32'h14;
        tick();
        check("t6_own0", 32'(obs_grant), 32'b01);
        m0_valid = 0; s_ready = 1;
        tick();
        check("t6_s_valid", 32'(obs_s_valid), 32'd0);
        s_ready = 0;
        tick();
        check("t6_idle", 32'(obs_grant), 32'd0);
        tick();
        check("t6_own1", 32'(obs_grant), 32'b10);
        idle_both();

        // Randomized traffic against the model.
        pend[0] = 0; pend[1] = 0;
        done_r[0] = 0; done_r[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (done_r[r]) pend[r] = 0;
                if (pend[r] && $urandom_range(0, 39) == 0) begin
                    pend[r] = 0;
                end else if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    ra[r] = $urandom();
                    rs[r] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
                    rd[r] = $urandom();
                end
            end
            m0_valid = pend[0]; m0_address = ra[0]; m0_wstrobe = rs[0]; m0_wdata = rd[0];
            m1_valid = pend[1]; m1_address = ra[1]; m1_wstrobe = rs[1]; m1_wdata = rd[1];
            reset = ($urandom_range(0, 149) == 0);
            s_ready = reset ? 1'b0 : ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 0;
        idle_both();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
